// File: rtl/serial_bus_frame_arbiter_pkg.sv
// Shared types and helpers for the round-robin serial frame arbiter.
// Holds the FSM state encoding, default CRC polynomial and frame-length helper.
package serial_bus_frame_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BODY,
        ST_CRCS,
        ST_STOP
    } state_t;

    // x^4 + x + 1 with the implicit top term dropped
    localparam logic [3:0] CRC_POLY_DEFAULT = 4'h3;

    function automatic int frame_len(input int src_w, input int addr_w,
                                     input int data_w, input int crc_w);
        return src_w + addr_w + data_w + crc_w + 2;
    endfunction

endpackage

// File: rtl/serial_bus_frame_arbiter_if.sv
// Station-side bundle: level requests, payloads, destinations in; acks, busy, grant and serial line out.
// Valid/ready: req[i] is a level valid sampled only in the grant cycle; ack[i] is the one-cycle completion.
interface serial_bus_frame_arbiter_if #(
    parameter int N_ST   = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) ();
    import serial_bus_frame_arbiter_pkg::*;

    localparam int SRC_W = (N_ST > 1) ? $clog2(N_ST) : 1;

    logic [N_ST-1:0]        req;
    logic [N_ST*DATA_W-1:0] data;
    logic [N_ST*ADDR_W-1:0] dst_addr;
    logic [N_ST-1:0]        ack;
    logic                   busy;
    logic [SRC_W-1:0]       grant_id;
    logic                   bus_out;
    state_t                 fsm_state;

    modport master (
        output req, data, dst_addr,
        input  ack, busy, grant_id, bus_out, fsm_state
    );

    modport slave (
        input  req, data, dst_addr,
        output ack, busy, grant_id, bus_out, fsm_state
    );

endinterface

// File: rtl/serial_bus_frame_arbiter_crc_serial.sv
// Bit-serial CRC LFSR: remainder of M(x)*x^CRC_W mod P, starting from zero.
module crc_serial
    import serial_bus_frame_arbiter_pkg::*;
#(
    parameter int               CRC_W    = 4,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc_out
);

    logic fb;

    assign fb = crc_out[CRC_W-1] ^ bit_in;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_out <= '0;
        end else if (clr) begin
            crc_out <= '0;
        end else if (en) begin
            crc_out <= {crc_out[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/serial_bus_frame_arbiter.sv
// Round-robin arbiter over N_ST stations that serialises the granted frame
// (start, SRC, DST, DATA, CRC, stop) MSB first onto a single idle-high line.
module serial_bus_frame_arbiter
    import serial_bus_frame_arbiter_pkg::*;
#(
    parameter int               N_ST     = 16,
    parameter int               DATA_W   = 64,
    parameter int               ADDR_W   = 4,
    parameter int               CRC_W    = 4,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEFAULT)
) (
    input logic                       clock,
    input logic                       reset_n,
    serial_bus_frame_arbiter_if.slave bus
);

    localparam int SRC_W   = (N_ST > 1) ? $clog2(N_ST) : 1;
    localparam int BODY_W  = SRC_W + ADDR_W + DATA_W;
    localparam int FRAME_L = frame_len(SRC_W, ADDR_W, DATA_W, CRC_W);
    localparam int CNT_W   = $clog2(FRAME_L);

    state_t            state;
    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  grant_id;
    logic [BODY_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [CRC_W-1:0]  crc_sh;
    logic [CRC_W-1:0]  crc_val;
    logic              bus_out_r;
    logic              busy_r;
    logic [N_ST-1:0]   ack_r;

    logic [SRC_W-1:0]  pick;
    logic              pick_vld;
    logic              crc_clr;
    logic              crc_en;

    // First requesting station at or above the pointer, wrapping at N_ST.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_ST; i++) begin
            if (!pick_vld && bus.req[(int'(ptr) + i) % N_ST]) begin
                pick     = SRC_W'((int'(ptr) + i) % N_ST);
                pick_vld = 1'b1;
            end
        end
    end

    // Each body bit is folded into the CRC on the edge that puts it on the line,
    // so the register is complete during the last body cycle.
    assign crc_clr = (state == ST_IDLE);
    assign crc_en  = (state == ST_START) ||
                     ((state == ST_BODY) && (cnt != CNT_W'(BODY_W - 1)));

    crc_serial #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY)
    ) u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (crc_clr),
        .en      (crc_en),
        .bit_in  (shreg[BODY_W-1]),
        .crc_out (crc_val)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            grant_id  <= '0;
            shreg     <= '0;
            cnt       <= '0;
            crc_sh    <= '0;
            bus_out_r <= 1'b1;
            busy_r    <= 1'b0;
            ack_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus_out_r <= 1'b1;
                    if (pick_vld) begin
                        grant_id  <= pick;
                        shreg     <= {pick,
                                      bus.dst_addr[pick*ADDR_W +: ADDR_W],
                                      bus.data[pick*DATA_W +: DATA_W]};
                        bus_out_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    bus_out_r <= shreg[BODY_W-1];
                    shreg     <= shreg << 1;
                    cnt       <= '0;
                    state     <= ST_BODY;
                end
                ST_BODY: begin
                    if (cnt == CNT_W'(BODY_W - 1)) begin
                        bus_out_r <= crc_val[CRC_W-1];
                        crc_sh    <= crc_val << 1;
                        cnt       <= '0;
                        state     <= ST_CRCS;
                    end else begin
                        bus_out_r <= shreg[BODY_W-1];
                        shreg     <= shreg << 1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                ST_CRCS: begin
                    if (cnt == CNT_W'(CRC_W - 1)) begin
                        bus_out_r       <= 1'b1;
                        ack_r[grant_id] <= 1'b1;
                        state           <= ST_STOP;
                    end else begin
                        bus_out_r <= crc_sh[CRC_W-1];
                        crc_sh    <= crc_sh << 1;
                        cnt       <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    ack_r  <= '0;
                    busy_r <= 1'b0;
                    ptr    <= (grant_id == SRC_W'(N_ST - 1)) ? '0 : grant_id + 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bus_out   = bus_out_r;
    assign bus.busy      = busy_r;
    assign bus.ack       = ack_r;
    assign bus.grant_id  = grant_id;
    assign bus.fsm_state = state;

endmodule
